// File: rtl/io_out_dispatcher.sv
// rtl/io_out_dispatcher.sv - queued write dispatcher to PS2/USB over four-phase req/ack with timeout
module io_out_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] Datos_in,
    input  logic [31:0] Dir_in,
    output logic [31:0] PS2_Datos,
    output logic [31:0] PS2_dir,
    output logic        PS2_req,
    input  logic        PS2_ack,
    output logic [31:0] USB_Datos,
    output logic [31:0] USB_dir,
    output logic        USB_req,
    input  logic        USB_ack,
    output logic        Estado_out,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Entry layout: [64]=target (1=PS2), [63:32]=address, [31:0]=data
    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [64:0]   head;

    state_t        state;
    logic          cur_sel;
    logic [15:0]   cnt;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          sel_ack;
    logic          expire;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign wr_ready   = !full;
    assign push       = wr_valid && !full;
    assign head       = mem[rd_ptr];
    // Only the device that owns the current transfer may complete it
    assign sel_ack    = cur_sel ? PS2_ack : USB_ack;
    assign expire     = ((cnt + 16'd1) == 16'(TIMEOUT));
    // The head stays queued while in flight; it leaves on ack or on timeout
    assign pop        = (state == REQ) && (sel_ack || expire);
    assign Estado_out = !empty || (state != IDLE);

    // Entry storage; no reset needed since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel, Dir_in, Datos_in};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Delivery FSM with registered device-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur_sel     <= 1'b0;
            cnt         <= '0;
            PS2_Datos   <= '0;
            PS2_dir     <= '0;
            PS2_req     <= 1'b0;
            USB_Datos   <= '0;
            USB_dir     <= '0;
            USB_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_sel <= head[64];
                        cnt     <= '0;
                        state   <= REQ;
                        if (head[64]) begin
                            PS2_Datos <= head[31:0];
                            PS2_dir   <= head[63:32];
                            PS2_req   <= 1'b1;
                        end else begin
                            USB_Datos <= head[31:0];
                            USB_dir   <= head[63:32];
                            USB_req   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (sel_ack) begin
                        PS2_req <= 1'b0;
                        USB_req <= 1'b0;
                        state   <= RELEASE;
                    end else if (expire) begin
                        PS2_req     <= 1'b0;
                        USB_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    if (!sel_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
